vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in clocks.
REQ-005 Parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 Parameter SYNC_ACTIVE, default 0, logic level of an asserted hsync/vsync.
REQ-010 clk  input  1  pixel clock, sole clock, rising edge.
REQ-011 reset  input  1  synchronous, active-high reset.
REQ-012 en  input  1  advance enable; low freezes the block.
REQ-013 col  output  10  current horizontal position, 0..H_TOTAL-1.
REQ-014 row  output  10  current vertical position, 0..V_TOTAL-1.
REQ-015 valid  output  1  high when col < H_VISIBLE and row < V_VISIBLE.
REQ-016 hsync  output  1  horizontal sync, level SYNC_ACTIVE when asserted.
REQ-017 vsync  output  1  vertical sync, level SYNC_ACTIVE when asserted.
REQ-018 frame_start  output  1  one-cycle pulse when col=0 and row=0.
REQ-019 line_end  output  1  one-cycle pulse when col=H_TOTAL-1.
REQ-020 frame_count  output  8  completed-frame counter, wraps 255->0.

Function
REQ-021 H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
REQ-022 Internal counters h_cnt and v_cnt; all outputs shall be registers loaded from the decode of the pre-advance counter values, giving one cycle of latency from counter to output.
REQ-023 On an enabled edge, h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
REQ-024 v_cnt wraps from V_TOTAL-1 to 0 only on the same edge that h_cnt wraps.
REQ-025 On the edge where both counters wrap, frame_count increments modulo 256.
REQ-026 hsync shall be asserted for output col in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751).
REQ-027 vsync shall be asserted for output row in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491), for whole lines, with edges aligned to col=0.
REQ-028 valid, hsync, vsync, frame_start and line_end shall be mutually time-aligned with col/row; none may lead or lag by a cycle.
REQ-029 When en=0 at an edge, the counters and all outputs shall hold their values; pulses held high stay high until the next enabled edge.
REQ-030 Counter comparisons shall use at least 10-bit unsigned arithmetic; no intermediate truncation.

Reset
REQ-031 An edge with reset=1 shall set h_cnt=0, v_cnt=0, col=0, row=0, valid=0, frame_start=0, line_end=0, frame_count=0, and hsync/vsync to ~SYNC_ACTIVE, regardless of en.
REQ-032 The first enabled edge after reset deassertion shall present col=0, row=0, valid=1, frame_start=1.
REQ-033 Reset asserted mid-frame shall take effect at the next edge; no partial line or frame completion shall be counted.

Verification
REQ-034 Reset, then 800 enabled clocks -> col sequences 0..799, row=0, valid high exactly 640 cycles, line_end high only at col=799.
REQ-035 Full frame of 420000 enabled clocks -> hsync low for cols 656..751 on every line, vsync low for rows 490..491 only, frame_count=1, frame_start pulsed once at the start.
REQ-036 Toggle en low for 7 cycles at col=639, row=479 -> all outputs frozen, next enabled edge gives col=640, valid=0.
REQ-037 Assert reset at col=300, row=200 -> next edge col=0, row=0, valid=0, frame_count=0; following enabled edge col=0, valid=1.
REQ-038 Run 256 frames -> frame_count wraps from 255 to 0 on the frame-end edge.
REQ-039 Set SYNC_ACTIVE=1 -> hsync/vsync polarities invert, timing unchanged.

Source files
------------

// File: rtl/vga_timing_if.sv
// Video timing bundle: advance enable in, raster position and sync/strobe outputs.
interface vga_timing_if;
  logic       en;
  logic [9:0] col;
  logic [9:0] row;
  logic       valid;
  logic       hsync;
  logic       vsync;
  logic       frame_start;
  logic       line_end;
  logic [7:0] frame_count;

  modport master (
    input  en,
    output col, row, valid, hsync, vsync, frame_start, line_end, frame_count
  );

  modport slave (
    output en,
    input  col, row, valid, hsync, vsync, frame_start, line_end, frame_count
  );
endinterface

// File: rtl/vga_timing.sv
// Raster timing generator: free-running h/v counters with a registered decode
// stage, so every output is aligned to the same (col,row) one cycle behind the counters.
module vga_timing #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  vga_timing_if.master  vif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       v_wrap;
  logic       valid_d;
  logic       hsync_d;
  logic       vsync_d;
  logic       frame_start_d;

  // Decode of the pre-advance counter values; registered below as outputs.
  always_comb begin
    h_wrap        = (h_cnt == H_LAST);
    v_wrap        = (v_cnt == V_LAST);
    valid_d       = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hsync_d       = ((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d       = ((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    frame_start_d = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      vif.col         <= '0;
      vif.row         <= '0;
      vif.valid       <= 1'b0;
      vif.hsync       <= ~SYNC_ACTIVE;
      vif.vsync       <= ~SYNC_ACTIVE;
      vif.frame_start <= 1'b0;
      vif.line_end    <= 1'b0;
      vif.frame_count <= '0;
    end else if (vif.en) begin
      h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
      if (h_wrap) begin
        v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
      end
      vif.col         <= h_cnt;
      vif.row         <= v_cnt;
      vif.valid       <= valid_d;
      vif.hsync       <= hsync_d;
      vif.vsync       <= vsync_d;
      vif.frame_start <= frame_start_d;
      vif.line_end    <= h_wrap;
      // Counted on the edge that presents the last pixel of the frame.
      if (h_wrap && v_wrap) begin
        vif.frame_count <= vif.frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: one full-size instance and two small-raster instances
// (opposite sync polarity) checked against an arithmetic raster model.
module tb_vga_timing;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic       valid;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
    logic       line_end;
    logic [7:0] fc;
  } out_t;

  // geometry per instance: hv hf hs hb vv vf vs vb
  int unsigned geo [3][8] = '{
    '{640, 16, 96, 48, 480, 10, 2, 33},
    '{8, 1, 2, 1, 4, 1, 1, 1},
    '{8, 1, 2, 1, 4, 1, 1, 1}
  };
  bit pol [3] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  longint unsigned n = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_timing_if ifa ();
  vga_timing_if ifb ();
  vga_timing_if ifc ();
  assign ifa.en = en;
  assign ifb.en = en;
  assign ifc.en = en;

  vga_timing dut_a (.clk(clk), .reset(reset), .vif(ifa));

  vga_timing #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE(1'b0)
  ) dut_b (.clk(clk), .reset(reset), .vif(ifb));

  vga_timing #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE(1'b1)
  ) dut_c (.clk(clk), .reset(reset), .vif(ifc));

  function automatic out_t actual(int d);
    out_t o;
    case (d)
      0: o = '{ifa.col, ifa.row, ifa.valid, ifa.hsync, ifa.vsync, ifa.frame_start, ifa.line_end, ifa.frame_count};
      1: o = '{ifb.col, ifb.row, ifb.valid, ifb.hsync, ifb.vsync, ifb.frame_start, ifb.line_end, ifb.frame_count};
      default: o = '{ifc.col, ifc.row, ifc.valid, ifc.hsync, ifc.vsync, ifc.frame_start, ifc.line_end, ifc.frame_count};
    endcase
    return o;
  endfunction

  // Expected outputs after k enabled edges since reset: edge k shows raster
  // position k-1, and every ht*vt edges one frame has completed.
  function automatic out_t model(int d, longint unsigned k);
    out_t o;
    longint unsigned ht, vt, p, c, r, hv, hs0, vv, vs0;
    bit sa;
    sa = pol[d];
    if (k == 0) begin
      o = '{10'd0, 10'd0, 1'b0, ~sa, ~sa, 1'b0, 1'b0, 8'd0};
      return o;
    end
    hv  = geo[d][0];
    vv  = geo[d][4];
    hs0 = hv + geo[d][1];
    vs0 = vv + geo[d][5];
    ht  = hv + geo[d][1] + geo[d][2] + geo[d][3];
    vt  = vv + geo[d][5] + geo[d][6] + geo[d][7];
    p = (k - 1) % (ht * vt);
    c = p % ht;
    r = p / ht;
    o.col         = 10'(c);
    o.row         = 10'(r);
    o.valid       = (c < hv) && (r < vv);
    o.hsync       = (c >= hs0 && c < hs0 + geo[d][2]) ? sa : ~sa;
    o.vsync       = (r >= vs0 && r < vs0 + geo[d][6]) ? sa : ~sa;
    o.frame_start = (c == 0) && (r == 0);
    o.line_end    = (c == ht - 1);
    o.fc          = 8'((k / (ht * vt)) % 256);
    return o;
  endfunction

  task automatic tick(input bit e, input bit r);
    en = e;
    reset = r;
    @(posedge clk);
    #1;
    if (r) n = 0;
    else if (e) n++;
  endtask

  task automatic test_reset();
    out_t g, x;
    for (int unsigned i = 0; i < 4; i++) begin
      tick(i[0], 1'b1);
      for (int d = 0; d < 3; d++) begin
        g = actual(d); x = model(d, n); total++;
        if (g !== x) begin
          bad++;
          $display("FAIL reset dut%0d got=%h exp=%h", d, g, x);
        end
      end
    end
  endtask

  task automatic test_first_line();
    out_t g, x;
    int vcnt = 0, lecnt = 0, hlow = 0;
    tick(1'b0, 1'b1);
    for (int unsigned i = 0; i < 800; i++) begin
      tick(1'b1, 1'b0);
      for (int d = 0; d < 3; d++) begin
        g = actual(d); x = model(d, n); total++;
        if (g !== x) begin
          bad++;
          $display("FAIL first_line dut%0d n=%0d got=%h exp=%h", d, n, g, x);
        end
      end
      if (ifa.valid) vcnt++;
      if (ifa.line_end) begin
        lecnt++;
        total++;
        if (ifa.col !== 10'd799) begin
          bad++;
          $display("FAIL line_end_pos got col=%0d exp=799", ifa.col);
        end
      end
      if (ifa.hsync == 1'b0) hlow++;
    end
    total++;
    if (vcnt != 640) begin bad++; $display("FAIL valid_count got=%0d exp=640", vcnt); end
    total++;
    if (lecnt != 1) begin bad++; $display("FAIL line_end_count got=%0d exp=1", lecnt); end
    total++;
    if (hlow != 96) begin bad++; $display("FAIL hsync_low_count got=%0d exp=96", hlow); end
  endtask

  task automatic test_freeze();
    out_t g, x, snap;
    tick(1'b0, 1'b1);
    // reach col=7,row=3 (last visible pixel) on the small raster
    for (int unsigned i = 0; i < 44; i++) tick(1'b1, 1'b0);
    snap = actual(1);
    total++;
    if (snap.col !== 10'd7 || snap.row !== 10'd3 || snap.valid !== 1'b1) begin
      bad++;
      $display("FAIL freeze_setup got=%h exp col=7 row=3 valid=1", snap);
    end
    for (int unsigned i = 0; i < 7; i++) begin
      tick(1'b0, 1'b0);
      for (int d = 0; d < 3; d++) begin
        g = actual(d); x = model(d, n); total++;
        if (g !== x) begin
          bad++;
          $display("FAIL freeze_hold dut%0d got=%h exp=%h", d, g, x);
        end
      end
    end
    tick(1'b1, 1'b0);
    g = actual(1); total++;
    if (g.col !== 10'd8 || g.row !== 10'd3 || g.valid !== 1'b0) begin
      bad++;
      $display("FAIL freeze_resume got=%h exp col=8 row=3 valid=0", g);
    end
  endtask

  task automatic test_midframe_reset();
    out_t g, x;
    tick(1'b0, 1'b1);
    for (int unsigned i = 0; i < 30; i++) tick(1'b1, 1'b0);
    g = actual(1); total++;
    if (g.col !== 10'd5 || g.row !== 10'd2) begin
      bad++;
      $display("FAIL midreset_setup got=%h exp col=5 row=2", g);
    end
    tick(1'b1, 1'b1);
    for (int d = 0; d < 3; d++) begin
      g = actual(d); x = model(d, n); total++;
      if (g !== x) begin
        bad++;
        $display("FAIL midreset_edge dut%0d got=%h exp=%h", d, g, x);
      end
    end
    tick(1'b1, 1'b0);
    for (int d = 0; d < 3; d++) begin
      g = actual(d); x = model(d, n); total++;
      if (g !== x) begin
        bad++;
        $display("FAIL midreset_after dut%0d got=%h exp=%h", d, g, x);
      end
    end
  endtask

  task automatic test_frame_wrap();
    out_t g, x;
    int fs_b = 0;
    tick(1'b0, 1'b1);
    for (int unsigned i = 0; i < 256 * 84; i++) begin
      tick(1'b1, 1'b0);
      if (ifb.frame_start) fs_b++;
      for (int d = 1; d < 3; d++) begin
        g = actual(d); x = model(d, n); total++;
        if (g !== x) begin
          bad++;
          $display("FAIL frame_wrap dut%0d n=%0d got=%h exp=%h", d, n, g, x);
        end
      end
      if (i == 255 * 84 - 2) begin
        total++;
        if (ifb.frame_count !== 8'd254) begin
          bad++;
          $display("FAIL fc_before_wrap got=%0d exp=254", ifb.frame_count);
        end
      end
    end
    total++;
    if (ifb.frame_count !== 8'd0) begin
      bad++;
      $display("FAIL fc_wrapped got=%0d exp=0", ifb.frame_count);
    end
    total++;
    if (fs_b != 256) begin
      bad++;
      $display("FAIL frame_start_count got=%0d exp=256", fs_b);
    end
  endtask

  task automatic test_random_en();
    out_t g, x;
    tick(1'b0, 1'b1);
    for (int unsigned i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
      for (int d = 0; d < 3; d++) begin
        g = actual(d); x = model(d, n); total++;
        if (g !== x) begin
          bad++;
          $display("FAIL random_en dut%0d n=%0d got=%h exp=%h", d, n, g, x);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_freeze();
    test_midframe_reset();
    test_frame_wrap();
    test_random_en();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
